// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and
// the default frame geometry used by uart_baudRateGen, uart_rx and uart_tx.
package uart_pkg;

    localparam int   DEFAULT_DATA_BITS  = 8;
    localparam int   DEFAULT_RESOLUTION = 16;
    localparam logic IDLE_LEVEL         = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high.
// Both flops reset to the idle level, so reset never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops: the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1 by default), fed by the baudTick oversample strobe.
// Samples every bit at mid-bit, pulses rxValid for one clk per good frame
// and frameErr for one clk per bad stop bit.
// Optional: define UART_RX_PARITY_EN to add an even-parity bit after the
// data bits and the parityErr output.
// RESOLUTION must be a power of two and at least 4; tickCnt relies on its
// natural wrap at RESOLUTION.
//
// Handshake: rxValid is a one-clk strobe with no ready; rxData holds the
// last good byte until the next rxValid, so the consumer must take it before
// then.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int RESOLUTION = DEFAULT_RESOLUTION
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 baudTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
`ifdef UART_RX_PARITY_EN
    output logic                 parityErr,
`endif
    output logic                 busy,
    output logic [2:0]           dbgState
);

    localparam int TICK_W = $clog2(RESOLUTION);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(RESOLUTION / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(RESOLUTION - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_rx_state_t       state;
    uart_rx_state_t       stateNext;
    logic                 rxS;
    logic [TICK_W-1:0]    tickCnt;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 tickMid;
    logic                 tickEnd;
    logic                 lastBit;
`ifdef UART_RX_PARITY_EN
    logic                 parBad;
`endif

    uart_rx_sync u_sync (
        .clk  (clk),
        .rstN (rstN),
        .d    (rx),
        .q    (rxS)
    );

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; nothing moves between ticks except IDLE and WAIT_HIGH,
    // which only watch the line level.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (rxS != IDLE_LEVEL) stateNext = START;
            START:     if (tickMid) stateNext = rxS ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (tickEnd && lastBit) stateNext = PARITY;
            PARITY:    if (tickEnd) stateNext = STOP;
`else
            DATA:      if (tickEnd && lastBit) stateNext = STOP;
`endif
            STOP:      if (tickEnd) stateNext = rxS ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxS) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Status outputs and the tick-position strobes used by both FSM and datapath.
    always_comb begin
        busy     = (state != IDLE);
        dbgState = state;
        tickMid  = baudTick && (tickCnt == TICK_MID);
        tickEnd  = baudTick && (tickCnt == TICK_END);
        lastBit  = (bitCnt == BIT_LAST);
    end

    // Oversample counter, bit counter and the LSB-first shift register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                START: begin
                    bitCnt <= '0;
                    if (tickMid) begin
                        tickCnt <= '0;
                    end else if (baudTick) begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                DATA, PARITY, STOP: begin
                    if (baudTick) tickCnt <= tickCnt + 1'b1;
                end
                default: tickCnt <= '0;
            endcase
            if ((state == DATA) && tickEnd) begin
                shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
        end
    end

    // Frame result: update rxData and pulse rxValid on a good stop bit,
    // pulse frameErr on a bad one.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxValid  <= (state == STOP) && tickEnd && rxS;
            frameErr <= (state == STOP) && tickEnd && !rxS;
            if ((state == STOP) && tickEnd && rxS) rxData <= shiftReg;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the XOR of data bits and parity bit must be 0. The error
    // is reported alongside rxValid, so a bad stop bit hides it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            parBad    <= 1'b0;
            parityErr <= 1'b0;
        end else begin
            if ((state == PARITY) && tickEnd) parBad <= rxS ^ (^shiftReg);
            parityErr <= (state == STOP) && tickEnd && rxS && parBad;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A free-running strobe stands in for
// uart_baudRateGen (one baudTick every 27 clk, so one bit = 432 clk at 16x).
// The reference model works at frame level: each frame sent is pushed as an
// expected byte or an expected framing error.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TICK_DIV = 27;
    localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;

    // ---------------- clock / reset / baud strobe ----------------
    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       baudTick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       busy;
    logic       parityErr;
    logic [2:0] dbgState;

    always #10 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 baudTick = 1'b1;
            @(posedge clk);
            #1 baudTick = 1'b0;
        end
    end

    uart_rx dut (
        .clk       (clk),
        .rstN      (rstN),
        .baudTick  (baudTick),
        .rx        (rx),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .frameErr  (frameErr),
`ifdef UART_RX_PARITY_EN
        .parityErr (parityErr),
`endif
        .busy      (busy),
        .dbgState  (dbgState)
    );

`ifndef UART_RX_PARITY_EN
    assign parityErr = 1'b0;
`endif

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    bit         got_pe_q[$];
    int         valid_cyc_q[$];
    int         cyc = 0;
    int         ferr_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    logic       busy_after_valid = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_valid) busy_after_valid = busy;
        if (rxValid) begin
            got_q.push_back(rxData);
            got_pe_q.push_back(parityErr);
            valid_cyc_q.push_back(cyc);
            if (frameErr) overlap_cnt++;
            if (prev_valid) wide_cnt++;
        end
        if (frameErr) begin
            ferr_cnt++;
            if (prev_ferr) wide_cnt++;
        end
        if (parityErr && !rxValid) overlap_cnt++;
        prev_valid = rxValid;
        prev_ferr  = frameErr;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] exp_q[$];
    bit         exp_pe_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;

    // ---------------- driver tasks ----------------
    task automatic drive_line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    // Sends one frame; flip inverts the even-parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit flip);
        drive_line(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_line(d[i], BIT_CLK);
        if (PAR_EN) drive_line((^d) ^ flip, BIT_CLK);
        drive_line(stop_bit, BIT_CLK);
        if (stop_bit) begin
            exp_q.push_back(d);
            exp_pe_q.push_back(PAR_EN ? flip : 1'b0);
            exp_data = d;
        end else begin
            exp_ferr++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstN = 1'b0;
        rx   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (rxData !== 8'h00) begin n_fail++; $display("FAIL reset_rxData: got %h expected 00", rxData); end
        n_checks++;
        if ({rxValid, frameErr, parityErr, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {rxValid, frameErr, parityErr, busy});
        end
        n_checks++;
        if (dbgState !== 3'(IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
        rstN = 1'b1;
        drive_line(1'b1, BIT_CLK);
    endtask

    task automatic test_valid_frame();
        logic [7:0] e, g;
        bit ep, gp;
        send_frame(8'hA5, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL a5_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ep = exp_pe_q.pop_front(); gp = got_pe_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL a5_data: got %h expected %h", g, e); end
            n_checks++;
            if (gp !== ep) begin n_fail++; $display("FAIL a5_parityErr: got %b expected %b", gp, ep); end
        end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
        n_checks++;
        if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL a5_frameErr: got %0d expected %0d", ferr_cnt, exp_ferr); end
        n_checks++;
        if (busy_after_valid !== 1'b0) begin n_fail++; $display("FAIL a5_busy_after: got %b expected 0", busy_after_valid); end
        n_checks++;
        if (rxData !== exp_data) begin n_fail++; $display("FAIL a5_hold: got %h expected %h", rxData, exp_data); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_line(1'b1, BIT_CLK);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        n_checks++;
        if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
        n_checks++;
        if (rxData !== exp_data) begin n_fail++; $display("FAIL ferr_hold: got %h expected %h", rxData, exp_data); end
        n_checks++;
        if (dbgState !== 3'(IDLE)) begin n_fail++; $display("FAIL ferr_state: got %0d expected %0d", dbgState, IDLE); end
        got_q.delete(); got_pe_q.delete();
    endtask

    task automatic test_glitch();
        logic [7:0] e, g;
        drive_line(1'b0, 3 * TICK_DIV);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_mid: got %b expected 1", busy); end
        drive_line(1'b1, 2 * BIT_CLK);
        n_checks++;
        if (got_q.size() != 0 || ferr_cnt !== exp_ferr) begin
            n_fail++; $display("FAIL glitch_pulse: got %0d valid, %0d ferr expected 0, %0d", got_q.size(), ferr_cnt, exp_ferr);
        end
        n_checks++;
        if (dbgState !== 3'(IDLE) || busy !== 1'b0) begin
            n_fail++; $display("FAIL glitch_idle: got state %0d busy %b expected %0d busy 0", dbgState, busy, IDLE);
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", g, e); end
        end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask

    task automatic test_break();
        logic [7:0] e, g;
        drive_line(1'b0, 30 * BIT_CLK);
        exp_ferr++;
        n_checks++;
        if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL break_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL break_valid: got %0d pulses expected 0", got_q.size()); end
        n_checks++;
        if (dbgState !== 3'(WAIT_HIGH) || busy !== 1'b1) begin
            n_fail++; $display("FAIL break_wait: got state %0d busy %b expected %0d busy 1", dbgState, busy, WAIT_HIGH);
        end
        drive_line(1'b1, BIT_CLK);
        n_checks++;
        if (dbgState !== 3'(IDLE)) begin n_fail++; $display("FAIL break_release: got %0d expected %0d", dbgState, IDLE); end
        send_frame(8'h81, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL break_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL break_data: got %h expected %h", g, e); end
        end
        n_checks++;
        if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL break_ferr_after: got %0d expected %0d", ferr_cnt, exp_ferr); end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, g;
        int gap;
        valid_cyc_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected 2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", g, e); end
        end
        if (valid_cyc_q.size() == 2) begin
            gap = valid_cyc_q[1] - valid_cyc_q[0];
            n_checks++;
            if (gap < FRAME_BITS * BIT_CLK - TICK_DIV || gap > FRAME_BITS * BIT_CLK + TICK_DIV) begin
                n_fail++; $display("FAIL b2b_gap: got %0d clk expected about %0d", gap, FRAME_BITS * BIT_CLK);
            end
        end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d, e, g;
        int ferr_before;
        d = 8'h5A;
        ferr_before = ferr_cnt;
        drive_line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_line(d[i], BIT_CLK);
        #5 rstN = 1'b0;
        #1;
        exp_data = 8'h00;
        n_checks++;
        if (rxData !== exp_data) begin n_fail++; $display("FAIL rstmid_rxData: got %h expected %h", rxData, exp_data); end
        n_checks++;
        if ({rxValid, frameErr, parityErr, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_flags: got %b expected 0000", {rxValid, frameErr, parityErr, busy});
        end
        n_checks++;
        if (dbgState !== 3'(IDLE)) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dbgState, IDLE); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        drive_line(1'b1, BIT_CLK);
        n_checks++;
        if (got_q.size() != 0 || ferr_cnt != ferr_before) begin
            n_fail++; $display("FAIL rstmid_pulse: got %0d valid %0d ferr expected 0 valid %0d ferr", got_q.size(), ferr_cnt, ferr_before);
        end
        send_frame(d, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", g, e); end
        end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] e, g;
        bit ep, gp;
        send_frame(8'h81, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CLK);
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL par_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ep = exp_pe_q.pop_front(); gp = got_pe_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL par_data: got %h expected %h", g, e); end
            n_checks++;
            if (gp !== ep) begin n_fail++; $display("FAIL par_err: got %b expected %b", gp, ep); end
        end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask
`endif

    task automatic test_random();
        logic [7:0] d, e, g;
        logic stop_bit;
        bit flip, ep, gp;
        for (int f = 0; f < 3; f++) begin
            d = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 3) != 0);
            flip = 1'($urandom_range(0, 1));
            send_frame(d, stop_bit, flip);
            drive_line(1'b1, BIT_CLK);
        end
        for (int i = 0; i < 2 * BIT_CLK && got_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ep = exp_pe_q.pop_front(); gp = got_pe_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rand_data: got %h expected %h", g, e); end
            n_checks++;
            if (gp !== ep) begin n_fail++; $display("FAIL rand_parityErr: got %b expected %b", gp, ep); end
        end
        n_checks++;
        if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
        n_checks++;
        if (rxData !== exp_data) begin n_fail++; $display("FAIL rand_hold: got %h expected %h", rxData, exp_data); end
        exp_q.delete(); exp_pe_q.delete(); got_q.delete(); got_pe_q.delete();
    endtask

    task automatic test_pulse_rules();
        n_checks++;
        if (overlap_cnt != 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d overlapping cycles expected 0", overlap_cnt); end
        n_checks++;
        if (wide_cnt != 0) begin n_fail++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", wide_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_valid_frame();
        test_frame_err();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
